// File: rtl/day10_pkg.sv
// Shared types and helpers for the day-10 record reader.
package day10_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_L,
    TARGET,
    CNT_B,
    BUTTONS,
    JOLT,
    DONE
  } state_t;

  // Number of w-bit beats needed to carry n mask bits.
  function automatic int unsigned beats_for(input int unsigned n, input int unsigned w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/day10_mask_unpacker.sv
// Places one mask beat at its slice of a light vector and clears bits beyond num_lights.
module day10_mask_unpacker
  import day10_pkg::*;
#(
  parameter int unsigned MAX_LIGHTS = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BEAT_W     = 2,
  parameter int unsigned LIGHTS_W   = 5
) (
  input  logic [BEAT_W-1:0]     beat_idx,
  input  logic [DATA_W-1:0]     tdata,
  input  logic [LIGHTS_W-1:0]   num_lights,
  output logic [MAX_LIGHTS-1:0] data_c,
  output logic [MAX_LIGHTS-1:0] wen_c
);

  localparam int unsigned MAX_VB = beats_for(MAX_LIGHTS, DATA_W);
  localparam int unsigned SPAN_W = MAX_VB * DATA_W;

  logic [SPAN_W-1:0]     span_data;
  logic [SPAN_W-1:0]     span_wen;
  logic [MAX_LIGHTS-1:0] in_range;

  always_comb begin
    span_data = '0;
    span_wen  = '0;
    in_range  = '0;
    for (int k = 0; k < MAX_VB; k++) begin
      if (beat_idx == BEAT_W'(k)) begin
        span_data[k*DATA_W +: DATA_W] = tdata;
        span_wen[k*DATA_W +: DATA_W]  = '1;
      end
    end
    for (int i = 0; i < MAX_LIGHTS; i++) begin
      in_range[i] = LIGHTS_W'(i) < num_lights;
    end
  end

  assign data_c = MAX_LIGHTS'(span_data) & in_range;
  assign wen_c  = MAX_LIGHTS'(span_wen);

endmodule

// File: rtl/day10_record_reader.sv
// Parses one machine record from a byte stream into flat registers for the solver,
// holding the result until the consumer accepts it.
module day10_record_reader
  import day10_pkg::*;
#(
  parameter  int unsigned MAX_LIGHTS  = 16,
  parameter  int unsigned MAX_BUTTONS = 16,
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned JOLT_W      = 10,
  parameter  int unsigned HAS_JOLTAGE = 1,
  localparam int unsigned LIGHTS_W    = $clog2(MAX_LIGHTS + 1),
  localparam int unsigned BUTTONS_W   = $clog2(MAX_BUTTONS + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic [DATA_W-1:0]                 s_tdata,
  input  logic                              s_tlast,
  input  logic                              start,
  output logic                              busy,
  output logic                              rec_valid,
  input  logic                              rec_ready,
  output logic                              rec_err,
  output logic                              end_of_input,
  output logic [LIGHTS_W-1:0]               num_lights,
  output logic [BUTTONS_W-1:0]              num_buttons,
  output logic [MAX_LIGHTS-1:0]             target,
  output logic [MAX_BUTTONS*MAX_LIGHTS-1:0] buttons,
  output logic [MAX_LIGHTS*JOLT_W-1:0]      joltage
);

  localparam int unsigned MAX_VB = beats_for(MAX_LIGHTS, DATA_W);
  localparam int unsigned BEAT_W = $clog2(MAX_VB + 1);

  state_t                state_q;
  state_t                state_d;
  logic [BEAT_W-1:0]     beat_idx;
  logic [BUTTONS_W-1:0]  btn_idx;
  logic [LIGHTS_W-1:0]   jolt_idx;
  int unsigned           vb;
  logic                  xfer;
  logic                  l_over;
  logic                  l_bad;
  logic                  b_over;
  logic                  b_zero;
  logic                  beat_last;
  logic                  btn_done;
  logic                  jolt_done;
  logic                  rec_final;
  logic                  err_c;
  logic [MAX_LIGHTS-1:0] slice_data;
  logic [MAX_LIGHTS-1:0] slice_wen;

  day10_mask_unpacker #(
    .MAX_LIGHTS (MAX_LIGHTS),
    .DATA_W     (DATA_W),
    .BEAT_W     (BEAT_W),
    .LIGHTS_W   (LIGHTS_W)
  ) u_unpack (
    .beat_idx   (beat_idx),
    .tdata      (s_tdata),
    .num_lights (num_lights),
    .data_c     (slice_data),
    .wen_c      (slice_wen)
  );

  // Beat classification; rec_final marks the beat allowed to carry tlast.
  assign xfer      = s_tvalid && s_tready;
  assign vb        = beats_for(32'(num_lights), DATA_W);
  assign l_over    = 32'(s_tdata) > MAX_LIGHTS;
  assign l_bad     = (s_tdata == '0) || l_over;
  assign b_over    = 32'(s_tdata) > MAX_BUTTONS;
  assign b_zero    = (s_tdata == '0);
  assign beat_last = (32'(beat_idx) + 32'd1) == vb;
  assign btn_done  = beat_last && ((32'(btn_idx) + 32'd1) == 32'(num_buttons));
  assign jolt_done = (32'(jolt_idx) + 32'd1) == 32'(num_lights);
  assign rec_final = ((state_q == CNT_B) && b_zero) ||
                     ((state_q == BUTTONS) && btn_done && (HAS_JOLTAGE == 0)) ||
                     ((state_q == JOLT) && jolt_done);
  assign err_c     = xfer && (((state_q == CNT_L) && l_bad) ||
                              ((state_q == CNT_B) && b_over) ||
                              (s_tlast && !rec_final));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !end_of_input) state_d = CNT_L;
      CNT_L:   if (xfer) state_d = err_c ? DONE : TARGET;
      TARGET:  if (xfer && (err_c || beat_last)) state_d = err_c ? DONE : CNT_B;
      CNT_B:   if (xfer) state_d = (err_c || b_zero) ? DONE : BUTTONS;
      BUTTONS: if (xfer && (err_c || btn_done))
                 state_d = (err_c || (HAS_JOLTAGE == 0)) ? DONE : JOLT;
      JOLT:    if (xfer && (err_c || jolt_done)) state_d = DONE;
      DONE:    if (rec_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_tready  = 1'b0;
    busy      = 1'b1;
    rec_valid = 1'b0;
    case (state_q)
      IDLE:    busy      = 1'b0;
      DONE:    rec_valid = 1'b1;
      default: s_tready  = 1'b1;
    endcase
  end

  // Record registers and beat counters; counters restart on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_err      <= 1'b0;
      end_of_input <= 1'b0;
      num_lights   <= '0;
      num_buttons  <= '0;
      target       <= '0;
      buttons      <= '0;
      joltage      <= '0;
      beat_idx     <= '0;
      btn_idx      <= '0;
      jolt_idx     <= '0;
    end else begin
      if ((state_q == IDLE) && (state_d == CNT_L)) begin
        target  <= '0;
        buttons <= '0;
        joltage <= '0;
        rec_err <= 1'b0;
      end
      if (xfer && s_tlast) end_of_input <= 1'b1;
      if (err_c) rec_err <= 1'b1;

      if (xfer) begin
        case (state_q)
          CNT_L:  num_lights  <= l_over ? LIGHTS_W'(MAX_LIGHTS) : LIGHTS_W'(s_tdata);
          TARGET: target      <= (target & ~slice_wen) | slice_data;
          CNT_B:  num_buttons <= b_over ? BUTTONS_W'(MAX_BUTTONS) : BUTTONS_W'(s_tdata);
          BUTTONS: begin
            for (int b = 0; b < MAX_BUTTONS; b++) begin
              if (btn_idx == BUTTONS_W'(b))
                buttons[b*MAX_LIGHTS +: MAX_LIGHTS] <=
                  (buttons[b*MAX_LIGHTS +: MAX_LIGHTS] & ~slice_wen) | slice_data;
            end
          end
          JOLT: begin
            if (HAS_JOLTAGE != 0) begin
              for (int i = 0; i < MAX_LIGHTS; i++) begin
                if (jolt_idx == LIGHTS_W'(i)) joltage[i*JOLT_W +: JOLT_W] <= JOLT_W'(s_tdata);
              end
            end
          end
          default: ;
        endcase
      end

      if (state_d != state_q) begin
        beat_idx <= '0;
        btn_idx  <= '0;
        jolt_idx <= '0;
      end else if (xfer) begin
        if ((state_q == TARGET) || (state_q == BUTTONS)) begin
          if (beat_last) begin
            beat_idx <= '0;
            btn_idx  <= btn_idx + 1'b1;
          end else begin
            beat_idx <= beat_idx + 1'b1;
          end
        end
        if (state_q == JOLT) jolt_idx <= jolt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_day10_record_reader.sv
// Randomized record bench for day10_record_reader against a byte-level parsing model.
module tb_day10_record_reader;

  localparam int unsigned ML = 16;
  localparam int unsigned MB = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned JW = 10;
  localparam int unsigned LW = 5;
  localparam int unsigned BW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic rec_ready = 1'b0;
  logic start = 1'b0;
  logic start_nj = 1'b0;
  logic [DW-1:0] s_tdata = '0;

  logic tready_a, busy_a, valid_a, err_a, eoi_a;
  logic [LW-1:0] nl_a;
  logic [BW-1:0] nb_a;
  logic [ML-1:0] tgt_a;
  logic [MB*ML-1:0] btn_a;
  logic [ML*JW-1:0] jlt_a;
  logic tready_b, busy_b, valid_b, err_b, eoi_b;
  logic [LW-1:0] nl_b;
  logic [BW-1:0] nb_b;
  logic [ML-1:0] tgt_b;
  logic [MB*ML-1:0] btn_b;
  logic [ML*JW-1:0] jlt_b;

  logic o_tready, o_busy, o_valid, o_err, o_eoi;
  logic [LW-1:0] o_nl;
  logic [BW-1:0] o_nb;
  logic [ML-1:0] o_tgt;
  logic [MB*ML-1:0] o_btn;
  logic [ML*JW-1:0] o_jlt;
  bit sel = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int rec_no = 0;

  logic [7:0] q[$];
  int rec_len;
  int e_nl, e_nb;
  logic e_err, e_eoi;
  logic [ML-1:0] e_tgt;
  logic [MB*ML-1:0] e_btn;
  logic [ML*JW-1:0] e_jlt;

  always #5 clk = ~clk;

  day10_record_reader dut (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(tready_a), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .start(start), .busy(busy_a), .rec_valid(valid_a), .rec_ready(rec_ready),
    .rec_err(err_a), .end_of_input(eoi_a), .num_lights(nl_a), .num_buttons(nb_a),
    .target(tgt_a), .buttons(btn_a), .joltage(jlt_a)
  );

  day10_record_reader #(.HAS_JOLTAGE(0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(tready_b), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .start(start_nj), .busy(busy_b), .rec_valid(valid_b), .rec_ready(rec_ready),
    .rec_err(err_b), .end_of_input(eoi_b), .num_lights(nl_b), .num_buttons(nb_b),
    .target(tgt_b), .buttons(btn_b), .joltage(jlt_b)
  );

  always_comb begin
    if (sel) begin
      o_tready = tready_b; o_busy = busy_b; o_valid = valid_b; o_err = err_b; o_eoi = eoi_b;
      o_nl = nl_b; o_nb = nb_b; o_tgt = tgt_b; o_btn = btn_b; o_jlt = jlt_b;
    end else begin
      o_tready = tready_a; o_busy = busy_a; o_valid = valid_a; o_err = err_a; o_eoi = eoi_a;
      o_nl = nl_a; o_nb = nb_a; o_tgt = tgt_a; o_btn = btn_a; o_jlt = jlt_a;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL rec %0d %s: got %0h expected %0h", rec_no, tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; start_nj = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; rec_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e_nl = 0; e_nb = 0; e_err = 1'b0; e_eoi = 1'b0;
    e_tgt = '0; e_btn = '0; e_jlt = '0;
  endtask

  // Walks the byte queue by the record format; returns beats consumed, tl = tlast beat index.
  task automatic model_core(input int has_j, input int tl, output int used);
    int l, b, vb, idx;
    e_tgt = '0; e_btn = '0; e_jlt = '0; e_err = 1'b0;
    l = int'(q[0]);
    used = 1;
    e_nl = (l > ML) ? ML : l;
    if (l == 0 || l > ML || tl == 0) begin e_err = 1'b1; return; end
    vb = (l + DW - 1) / DW;
    for (int k = 0; k < vb; k++) begin
      idx = used; used++;
      for (int j = 0; j < DW; j++) if (k*DW + j < l && q[idx][j]) e_tgt[k*DW + j] = 1'b1;
      if (idx == tl) begin e_err = 1'b1; return; end
    end
    idx = used; used++;
    b = int'(q[idx]);
    e_nb = (b > MB) ? MB : b;
    if (b > MB) begin e_err = 1'b1; return; end
    if (b == 0) return;
    if (idx == tl) begin e_err = 1'b1; return; end
    for (int bb = 0; bb < b; bb++) begin
      for (int k = 0; k < vb; k++) begin
        idx = used; used++;
        for (int j = 0; j < DW; j++)
          if (k*DW + j < l && q[idx][j]) e_btn[bb*ML + k*DW + j] = 1'b1;
        if (idx == tl && !(bb == b - 1 && k == vb - 1 && has_j == 0)) begin
          e_err = 1'b1; return;
        end
      end
    end
    if (has_j == 0) return;
    for (int i = 0; i < l; i++) begin
      idx = used; used++;
      e_jlt[i*JW +: JW] = JW'(q[idx]);
      if (idx == tl && i != l - 1) begin e_err = 1'b1; return; end
    end
  endtask

  task automatic gen(input int l, input int b, input int has_j);
    int vb;
    q.delete();
    q.push_back(8'(l));
    if (l >= 1 && l <= ML) begin
      vb = (l + DW - 1) / DW;
      repeat (vb) q.push_back(8'($urandom));
      q.push_back(8'(b));
      if (b >= 1 && b <= MB) begin
        repeat (b * vb) q.push_back(8'($urandom));
        if (has_j != 0) repeat (l) q.push_back(8'($urandom));
      end
    end
    rec_len = q.size();
    repeat (4) q.push_back(8'($urandom));
  endtask

  task automatic run_record(input bit s, input int has_j, input int tl);
    int used, ptr, cyc, hold;
    bit fire, last_fire, v;
    rec_no++;
    model_core(has_j, tl, used);
    if (tl >= 0 && tl < used) e_eoi = 1'b1;
    sel = s;
    @(negedge clk);
    if (s) start_nj = 1'b1; else start = 1'b1;
    ptr = 0; fire = 1'b0; last_fire = 1'b0; cyc = 0;
    forever begin
      @(posedge clk);
      if (fire) ptr++;
      last_fire = fire;
      fire = 1'b0;
      @(negedge clk);
      start = 1'b0; start_nj = 1'b0;
      if (o_valid || cyc >= 400) break;
      v = ($urandom_range(0, 3) != 0);
      s_tvalid = v;
      s_tdata = (ptr < q.size()) ? q[ptr] : 8'h00;
      s_tlast = (ptr == tl);
      fire = v && o_tready;
      cyc++;
    end
    chk("valid", 256'(o_valid), 256'(1));
    if (!o_valid) begin do_reset(); return; end
    chk("beats", 256'(ptr), 256'(used));
    chk("latency", 256'(last_fire), 256'(1));
    chk("num_lights", 256'(o_nl), 256'(e_nl));
    chk("num_buttons", 256'(o_nb), 256'(e_nb));
    chk("target", 256'(o_tgt), 256'(e_tgt));
    chk("buttons", 256'(o_btn), 256'(e_btn));
    chk("joltage", 256'(o_jlt), 256'(e_jlt));
    chk("rec_err", 256'(o_err), 256'(e_err));
    chk("eoi", 256'(o_eoi), 256'(e_eoi));
    chk("busy", 256'(o_busy), 256'(1));
    hold = $urandom_range(1, 5);
    s_tvalid = 1'b1; s_tlast = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("done_tready", 256'(o_tready), 256'(0));
      chk("hold_valid", 256'(o_valid), 256'(1));
      chk("hold_target", 256'(o_tgt), 256'(e_tgt));
    end
    rec_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rec_ready = 1'b0; s_tvalid = 1'b0;
    chk("idle_busy", 256'(o_busy), 256'(0));
    chk("idle_valid", 256'(o_valid), 256'(0));
  endtask

  task automatic chk_start_ignored();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("start_ignored", 256'(busy_a), 256'(0));
  endtask

  initial begin
    int l, b, mode, tl;
    do_reset();
    chk("rst_tready", 256'(o_tready), 256'(0));
    chk("rst_busy", 256'(o_busy), 256'(0));
    chk("rst_valid", 256'(o_valid), 256'(0));
    chk("rst_err", 256'(o_err), 256'(0));
    chk("rst_eoi", 256'(o_eoi), 256'(0));
    chk("rst_nl", 256'(o_nl), 256'(0));
    chk("rst_nb", 256'(o_nb), 256'(0));
    chk("rst_target", 256'(o_tgt), 256'(0));
    chk("rst_buttons", 256'(o_btn), 256'(0));
    chk("rst_joltage", 256'(o_jlt), 256'(0));

    // Random well-formed and bad-count records, no tlast.
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 9);
      l = $urandom_range(1, 16);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 5);
      if (mode == 0) l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 40);
      if (mode == 1) b = $urandom_range(17, 30);
      gen(l, b, 1);
      run_record(1'b0, 1, -1);
    end

    q = '{8'd12, 8'hFF, 8'hFF, 8'd0, 8'h11, 8'h22};
    run_record(1'b0, 1, -1);
    chk("l12_target", 256'(o_tgt), 256'(16'h0FFF));

    q = '{8'd20, 8'h01, 8'h02, 8'h03, 8'h04};
    run_record(1'b0, 1, -1);
    chk("l20_err", 256'(o_err), 256'(1));
    chk("l20_nl", 256'(o_nl), 256'(16));

    q = '{8'd4, 8'h06, 8'd2, 8'h03, 8'h0C, 8'd3, 8'd5, 8'd4, 8'd7, 8'hAA, 8'h55};
    run_record(1'b0, 1, 8);
    chk("ex_target", 256'(o_tgt), 256'(6));
    chk("ex_buttons", 256'(o_btn), 256'(32'h000C_0003));
    chk("ex_joltage", 256'(o_jlt),
        (256'(3)) | (256'(5) << 10) | (256'(4) << 20) | (256'(7) << 30));
    chk("ex_eoi", 256'(o_eoi), 256'(1));
    chk("ex_err", 256'(o_err), 256'(0));
    chk_start_ignored();

    do_reset();
    q = '{8'd4, 8'h09, 8'd3, 8'h01, 8'h02, 8'h04, 8'd1, 8'd2, 8'd3, 8'd4, 8'h77};
    run_record(1'b0, 1, 4);
    chk("tl_btn_err", 256'(o_err), 256'(1));
    chk("tl_btn_eoi", 256'(o_eoi), 256'(1));
    chk_start_ignored();

    // Random tlast on an interior beat of a well-formed record.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      gen($urandom_range(1, 16), $urandom_range(1, 4), 1);
      tl = $urandom_range(0, rec_len - 2);
      run_record(1'b0, 1, tl);
    end

    // Reset while in BUTTONS.
    do_reset();
    rec_no++;
    sel = 1'b0;
    gen(4, 3, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = q[i];
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    chk("mid_busy", 256'(o_busy), 256'(1));
    chk("mid_tready", 256'(o_tready), 256'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 256'(o_busy), 256'(0));
    chk("mrst_valid", 256'(o_valid), 256'(0));
    chk("mrst_tready", 256'(o_tready), 256'(0));
    chk("mrst_nl", 256'(o_nl), 256'(0));
    chk("mrst_nb", 256'(o_nb), 256'(0));
    chk("mrst_target", 256'(o_tgt), 256'(0));
    chk("mrst_buttons", 256'(o_btn), 256'(0));
    rst_n = 1'b1;
    e_nl = 0; e_nb = 0; e_err = 1'b0; e_eoi = 1'b0;
    e_tgt = '0; e_btn = '0; e_jlt = '0;

    // Variant without the joltage field.
    gen(5, 0, 0);
    run_record(1'b1, 0, -1);
    chk("nj_b0_nb", 256'(o_nb), 256'(0));
    gen(9, 2, 0);
    run_record(1'b1, 0, -1);
    chk("nj_joltage", 256'(o_jlt), 256'(0));
    for (int r = 0; r < 5; r++) begin
      gen($urandom_range(1, 16), $urandom_range(0, 6), 0);
      run_record(1'b1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
